// File: rtl/y86_instr_packer.sv
// y86_instr_packer
// Takes one decoded Y86-64 instruction (icode, ifun, rA, rB, valC) and writes
// its encoded byte stream into instruction memory, one byte per cycle, at an
// auto-incrementing byte address. This is the inverse of the fetch-stage
// byte splitter.
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   in_valid / in_ready     instruction handshake (fields sampled at accept)
//   icode, ifun, rA, rB     decoded instruction fields
//   valC                    constant word, emitted little-endian
//   base_load, base_addr    reload the write pointer (honored only when idle)
//   mem_we / mem_ready      byte write handshake
//   mem_addr, mem_byte      byte address and data
//   busy                    instruction in flight
//   done                    one-cycle pulse after the last byte is accepted
//   err                     one-cycle pulse after an instruction is rejected
//
// Build option: define Y86_IFUN_CHECK_EN to reject ifun values that are not
// legal for the given icode. Without it, only icode C..F is rejected.
module y86_instr_packer #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [63:0]       valC,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_byte,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr;
  // Encoded instruction held as a byte shift register: byte 0 in [7:0],
  // shifted down by one byte on each accepted write.
  logic [79:0]       img;
  logic [3:0]        left;      // bytes still to be written

  logic [79:0]       img_new;
  logic [3:0]        len_new;
  logic              ok;
  logic              accept;
  logic              hs;

  // Encode the presented fields into a byte image and a length.
  always_comb begin
    img_new = '0;
    len_new = 4'd0;
    ok      = 1'b1;
    case (icode)
      4'h0, 4'h1, 4'h9: begin
        img_new[7:0] = {icode, ifun};
        len_new      = 4'd1;
      end
      4'h2, 4'h6, 4'hA, 4'hB: begin
        img_new[15:0] = {rA, rB, icode, ifun};
        len_new       = 4'd2;
      end
      4'h7, 4'h8: begin
        img_new[71:0] = {valC, icode, ifun};
        len_new       = 4'd9;
      end
      4'h3, 4'h4, 4'h5: begin
        img_new = {valC, rA, rB, icode, ifun};
        len_new = 4'd10;
      end
      default: ok = 1'b0;
    endcase
`ifdef Y86_IFUN_CHECK_EN
    case (icode)
      4'h6:       if (ifun > 4'd3) ok = 1'b0;
      4'h2, 4'h7: if (ifun > 4'd6) ok = 1'b0;
      default:    if (ifun != 4'd0) ok = 1'b0;
    endcase
`endif
  end

  assign accept = in_valid && in_ready;
  assign hs     = (state == EMIT) && mem_ready;

  // Next state and outputs.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_byte = 8'h00;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst_n so in_ready reads 0 while reset is held.
        in_ready = rst_n;
        if (accept && ok) state_nx = EMIT;
      end
      EMIT: begin
        mem_we   = 1'b1;
        mem_addr = ptr;
        mem_byte = img[7:0];
        busy     = 1'b1;
        if (hs && left == 4'd1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      img   <= '0;
      left  <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      err   <= 1'b0;
      if (state == IDLE) begin
        // base_load takes effect before a same-cycle accept: the first byte
        // is emitted next cycle from the freshly loaded ptr.
        if (base_load) ptr <= base_addr;
        if (accept) begin
          if (ok) begin
            img  <= img_new;
            left <= len_new;
          end else begin
            err <= 1'b1;
          end
        end
      end else if (hs) begin
        ptr  <= ptr + ADDR_W'(1);
        img  <= {8'h00, img[79:8]};
        left <= left - 4'd1;
        done <= (left == 4'd1);
      end
    end
  end

endmodule

// File: tb/tb_y86_instr_packer.sv
module tb_y86_instr_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC;
  logic        base_load;
  logic [63:0] base_addr;
  logic        mem_we, mem_ready;
  logic [63:0] mem_addr;
  logic [7:0]  mem_byte;
  logic        busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] mptr;   // model write pointer

  always #5 clk = ~clk;

  y86_instr_packer #(.ADDR_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
    .base_load(base_load), .base_addr(base_addr),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_byte(mem_byte), .busy(busy), .done(done), .err(err)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference rules: instruction length, 0 for rejected instructions.
  function automatic int ref_len(input logic [3:0] ic, input logic [3:0] fn);
    int n;
    case (ic)
      4'h0, 4'h1, 4'h9:       n = 1;
      4'h2, 4'h6, 4'hA, 4'hB: n = 2;
      4'h7, 4'h8:             n = 9;
      4'h3, 4'h4, 4'h5:       n = 10;
      default:                n = 0;
    endcase
`ifdef Y86_IFUN_CHECK_EN
    if (ic == 4'h6 && fn > 3) n = 0;
    else if ((ic == 4'h2 || ic == 4'h7) && fn > 6) n = 0;
    else if (ic != 4'h6 && ic != 4'h2 && ic != 4'h7 && fn != 0) n = 0;
`endif
    return n;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [3:0] ic, fn, ra, rb,
                                          input logic [63:0] vc, input int k);
    logic [63:0] t;
    int has_regs;
    has_regs = (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) ? 1 : 0;
    if (k == 0) return {ic, fn};
    if (has_regs != 0 && k == 1) return {ra, rb};
    t = vc >> (8 * (k - 1 - has_regs));
    return t[7:0];
  endfunction

  // Issue one instruction from IDLE and follow it to completion.
  // mode: 0 = mem_ready held high, 1 = 1,0,0 repeating, 2 = random.
  task automatic issue(input logic [3:0] ic, fn, ra, rb, input logic [63:0] vc,
                       input logic bl, input logic [63:0] ba, input int mode,
                       output logic got_err, output logic [7:0] b0);
    int n, k, cyc;
    got_err = 1'b0;
    b0 = 8'h00;
    chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; icode = ic; ifun = fn; rA = ra; rB = rb; valC = vc;
    base_load = bl; base_addr = ba;
    @(posedge clk); #1;
    if (bl) mptr = ba;
    // Scramble the fields: they must have been captured at the accept.
    in_valid = 1'b0; base_load = 1'b0;
    icode = 4'($urandom); ifun = 4'($urandom); rA = 4'($urandom); rB = 4'($urandom);
    valC = {$urandom, $urandom};
    n = ref_len(ic, fn);
    if (n == 0) begin
      got_err = err;
      chk("err_pulse", {63'd0, err}, 64'd1);
      chk("err_no_we", {63'd0, mem_we}, 64'd0);
      chk("err_no_done", {63'd0, done}, 64'd0);
      chk("err_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      chk("err_one_cycle", {63'd0, err}, 64'd0);
      return;
    end
    k = 0; cyc = 0;
    while (k < n && cyc < 200) begin
      mem_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom);
      // base_load during EMIT must be ignored.
      base_load = 1'($urandom); base_addr = {$urandom, $urandom};
      if (k == 0 && cyc == 0) b0 = mem_byte;
      chk("emit_we", {63'd0, mem_we}, 64'd1);
      chk("emit_addr", mem_addr, mptr);
      chk("emit_byte", {56'd0, mem_byte}, {56'd0, ref_byte(ic, fn, ra, rb, vc, k)});
      chk("emit_busy", {63'd0, busy}, 64'd1);
      chk("emit_in_ready", {63'd0, in_ready}, 64'd0);
      chk("emit_done_err", {62'd0, done, err}, 64'd0);
      if (mem_ready) begin k++; mptr++; end
      cyc++;
      @(posedge clk); #1;
    end
    base_load = 1'b0; mem_ready = 1'b1;
    if (k < n) chk("emit_timeout", 64'(k), 64'(n));
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("after_we", {63'd0, mem_we}, 64'd0);
    chk("after_in_ready", {63'd0, in_ready}, 64'd1);
    chk("after_busy", {63'd0, busy}, 64'd0);
    chk("after_err", {63'd0, err}, 64'd0);
  endtask

  typedef struct {
    logic [3:0]  ic, fn, ra, rb;
    logic [63:0] vc;
    logic        bl;
    logic [63:0] ba;
    int          mode;
    logic        exp_err;
    logic [7:0]  exp_b0;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic       ge;
    logic [7:0] b0;

    vecs[0] = '{4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF, 1'b1, 64'h100, 0, 1'b0, 8'h30};
    vecs[1] = '{4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, 64'h0, 0, 1'b0, 8'h00};  // lands at 0x10A
    vecs[2] = '{4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, 64'h0, 0, 1'b0, 8'h10};
    vecs[3] = '{4'h9, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, 64'h0, 0, 1'b0, 8'h90};
    vecs[4] = '{4'h8, 4'h0, 4'hF, 4'hF, 64'h40, 1'b0, 64'h0, 1, 1'b0, 8'h80};
    vecs[5] = '{4'hE, 4'h0, 4'h1, 4'h2, 64'h55, 1'b0, 64'h0, 0, 1'b1, 8'h00};
`ifdef Y86_IFUN_CHECK_EN
    vecs[6] = '{4'h6, 4'h5, 4'h1, 4'h2, 64'h0, 1'b0, 64'h0, 0, 1'b1, 8'h00};
`else
    vecs[6] = '{4'h6, 4'h5, 4'h1, 4'h2, 64'h0, 1'b0, 64'h0, 0, 1'b0, 8'h65};
`endif
    vecs[7] = '{4'h7, 4'h0, 4'hF, 4'hF, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1'b0, 8'h70};
    vecs[8] = '{4'h2, 4'h3, 4'h4, 4'h5, 64'h0, 1'b0, 64'h0, 2, 1'b0, 8'h23};
    vecs[9] = '{4'hA, 4'h0, 4'h7, 4'hF, 64'h0, 1'b0, 64'h0, 1, 1'b0, 8'hA0};

    rst_n = 1'b0; in_valid = 1'b0; icode = 0; ifun = 0; rA = 0; rB = 0; valC = 0;
    base_load = 1'b0; base_addr = 0; mem_ready = 1'b1; mptr = 0;

    // Reset state
    #12;
    chk("rst_in_ready_low", {63'd0, in_ready}, 64'd0);
    chk("rst_outputs", {60'd0, mem_we, busy, done, err}, 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_byte", {56'd0, mem_byte}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

    // Directed table
    foreach (vecs[i]) begin
      issue(vecs[i].ic, vecs[i].fn, vecs[i].ra, vecs[i].rb, vecs[i].vc,
            vecs[i].bl, vecs[i].ba, vecs[i].mode, ge, b0);
      chk($sformatf("vec%0d_err", i), {63'd0, ge}, {63'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_b0", i), {56'd0, b0}, {56'd0, vecs[i].exp_b0});
    end

    // Reset in the middle of an mrmovq after its 4th byte
    in_valid = 1'b1; icode = 4'h5; ifun = 4'h0; rA = 4'h3; rB = 4'h4;
    valC = 64'h1122334455667788; mem_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("mid_still_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {60'd0, mem_we, busy, done, err}, 64'd0);
    chk("mid_rst_addr", mem_addr, 64'd0);
    chk("mid_rst_byte", {56'd0, mem_byte}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    #2 rst_n = 1'b1;
    mptr = 0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("mid_rel_in_ready", {63'd0, in_ready}, 64'd1);
      chk("mid_rel_no_done", {62'd0, done, mem_we}, 64'd0);
    end
    issue(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, 64'h0, 0, ge, b0);

    // Randomized instructions against the reference rules
    for (int r = 0; r < 60; r++) begin
      logic [3:0]  ic, fn;
      logic        bl;
      logic [63:0] ba;
      ic = 4'($urandom_range(0, 15));
      fn = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      bl = ($urandom % 6 == 0);
      ba = ($urandom % 2 == 0) ? {$urandom, $urandom} : (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)));
      issue(ic, fn, 4'($urandom), 4'($urandom), {$urandom, $urandom}, bl, ba,
            $urandom_range(0, 2), ge, b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
